note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Plays a programmable melody by stepping through a DEPTH-entry note table and driving the
//  tone generator's 12-bit frequency word plus a note_on gate. Each entry holds note, sharp,
//  octave, rest and duration. The block sits between the board/host control and the tone generator.
//  It uses the same note/octave encoding as the switch interface.
// PARAMETERS
//  DEPTH       16       note table entries; power of two
//  AW          4        table address width, log2(DEPTH)
//  TICK_DIV    100000   clk cycles per base tick (1 kHz at 100 MHz)
//  UNIT_TICKS  125      base ticks per duration unit
//  GAP_TICKS   1        base ticks of silence between consecutive entries (>=1)
// PORTS
//  clk      in   1    system clock
//  rst      in   1    synchronous reset, active-high
//  start    in   1    pulse: begin playback at entry 0 (ignored unless idle)
//  stop     in   1    pulse: abort playback, return to idle
//  wr_en    in   1    table write strobe
//  wr_addr  in   AW   table write address
//  wr_data  in   10   entry: [9]rest [8:7]oct [6]sharp [5:3]note [2:0]dur
//  freq     out  12   frequency word, Hz, to tone generator
//  note_on  out  1    gate: 1 while a non-rest note sounds
//  busy     out  1    1 in any state except IDLE
//  step     out  AW   index of entry currently loaded/playing
//  done     out  1    one-cycle pulse when a non-looping sequence finishes
// BEHAVIOUR
//  Reset: state=IDLE, freq=440, note_on=0, busy=0, step=0, done=0, prescaler/counters=0.
//   Table contents are not reset.
//  Encoding: note 0..6 = C D E F G A B; note 7 = END marker. sharp raises a half step
//   (C#277 D#311 F#370 G#415 A#466); sharp on E/B is ignored. Naturals: 261 293 330 349 392 440 494.
//   oct: 0 = base, 1 = <<1, 2 = <<2, 3 = >>1; max 494<<2 = 1976 fits in 12 bits.
//  FSM IDLE -> LOAD -> PLAY -> GAP -> LOAD ...
//   IDLE: on start (and !stop): step<=0, go to LOAD.
//   LOAD (1 cycle): register table[step]. If END: go to end handling. Otherwise freq<=decoded value,
//    note_on<=!rest, prescaler cleared, go to PLAY. freq/note_on are valid 2 cycles after start.
//   PLAY: lasts exactly (dur+1)*UNIT_TICKS*TICK_DIV cycles, then note_on<=0 and go to GAP.
//   GAP: lasts GAP_TICKS*TICK_DIV cycles; freq holds. Then step<=step+1 and go to LOAD.
//  End handling: triggered by the END marker, or by finishing GAP with step=DEPTH-1
//   (step wraps to 0 and is treated as end).
//  stop: from any state, IDLE next cycle; note_on<=0; freq holds; no done pulse.
//   start and stop in the same cycle: stop wins.
//  start while busy: ignored.
//  Writes accepted in any state, 1-cycle write. A write to the entry being played takes effect
//   at that entry's next LOAD. A write and a LOAD to the same address in the same cycle
//   return the old data.
// CONFIGURATION
//  SEQ_LOOP_EN defined: on end handling, step<=0 and go to LOAD (endless loop, done never pulses).
//   If entry 0 is END, go to IDLE with done=1 to avoid a livelock.
//  SEQ_LOOP_EN undefined: on end handling, go to IDLE, note_on=0, done=1 for one cycle.
// STRUCTURE
//  synth_pkg: note codes, END code, octave codes, natural/sharp frequency constants, FSM state encoding.
//  Sub-module note_to_freq: combinational (note, sharp, oct) -> 12-bit freq. Shared with the switch path.
//  Top level holds the table RAM, prescaler, duration counter and FSM.
// TESTING  (TICK_DIV=4, UNIT_TICKS=2, GAP_TICKS=1, DEPTH=16)
//  1. Reset -> freq=440, note_on=0, busy=0, step=0.
//  2. Write entry0 = A, oct0, dur1; entry1 = END; pulse start.
//     -> freq=440 and note_on=1 two cycles later, for 16 cycles; then 4 gap cycles;
//        then done pulses once (loop off).
//  3. Entry0 = C sharp oct1 -> freq=554. Entry0 = E sharp oct2 -> freq=1320.
//     Entry0 = B oct3 -> freq=247.
//  4. Rest entry dur0 -> note_on stays 0 for 8 cycles while step advances.
//  5. All 16 entries filled, no END -> plays steps 0..15, then done (loop off)
//     or restarts at step 0 (SEQ_LOOP_EN).
//  6. stop mid-PLAY, and start+stop in the same cycle -> IDLE next cycle, note_on=0, no done pulse.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared note/octave encoding, tone constants and sequencer state encoding.
// Used by both the note sequencer and the switch-driven tone path.
package synth_pkg;

  typedef enum logic [2:0] {
    NOTE_C   = 3'd0,
    NOTE_D   = 3'd1,
    NOTE_E   = 3'd2,
    NOTE_F   = 3'd3,
    NOTE_G   = 3'd4,
    NOTE_A   = 3'd5,
    NOTE_B   = 3'd6,
    NOTE_END = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    OCT_BASE  = 2'd0,
    OCT_UP1   = 2'd1,
    OCT_UP2   = 2'd2,
    OCT_DOWN1 = 2'd3
  } oct_e;

  localparam logic [11:0] F_C  = 12'd261;
  localparam logic [11:0] F_D  = 12'd293;
  localparam logic [11:0] F_E  = 12'd330;
  localparam logic [11:0] F_F  = 12'd349;
  localparam logic [11:0] F_G  = 12'd392;
  localparam logic [11:0] F_A  = 12'd440;
  localparam logic [11:0] F_B  = 12'd494;
  localparam logic [11:0] F_CS = 12'd277;
  localparam logic [11:0] F_DS = 12'd311;
  localparam logic [11:0] F_FS = 12'd370;
  localparam logic [11:0] F_GS = 12'd415;
  localparam logic [11:0] F_AS = 12'd466;

  localparam logic [11:0] F_RESET = F_A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  // Table entry layout: [9]rest [8:7]oct [6]sharp [5:3]note [2:0]dur
  typedef struct packed {
    logic       rest;
    logic [1:0] oct;
    logic       sharp;
    logic [2:0] note;
    logic [2:0] dur;
  } entry_t;

endpackage

// File: rtl/note_to_freq.sv
// Combinational (note, sharp, octave) to 12-bit frequency word in Hz.
// Sharp on E and B has no effect; the END code maps to 0.
module note_to_freq
  import synth_pkg::*;
(
  input  logic [2:0]  note,
  input  logic        sharp,
  input  logic [1:0]  oct,
  output logic [11:0] freq
);

  logic [11:0] base;

  always_comb begin
    base = 12'd0;
    case (note)
      NOTE_C:  base = sharp ? F_CS : F_C;
      NOTE_D:  base = sharp ? F_DS : F_D;
      NOTE_E:  base = F_E;
      NOTE_F:  base = sharp ? F_FS : F_F;
      NOTE_G:  base = sharp ? F_GS : F_G;
      NOTE_A:  base = sharp ? F_AS : F_A;
      NOTE_B:  base = F_B;
      default: base = 12'd0;
    endcase
  end

  // Highest result is B shifted up two octaves (1976), so 12 bits never overflow.
  always_comb begin
    freq = base;
    case (oct)
      OCT_BASE:  freq = base;
      OCT_UP1:   freq = base << 1;
      OCT_UP2:   freq = base << 2;
      OCT_DOWN1: freq = base >> 1;
      default:   freq = base;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps through a note table and drives freq/note_on to the tone generator.
// Define SEQ_LOOP_EN to replay the table endlessly instead of stopping with a done pulse.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int TICK_DIV   = 100000,
  parameter int UNIT_TICKS = 125,
  parameter int GAP_TICKS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [9:0]    wr_data,
  output logic [11:0]   freq,
  output logic          note_on,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 16;

  entry_t        table_mem [DEPTH];
  entry_t        rd_data_reg;
  state_e        state_reg, state_next;
  logic [AW-1:0] step_reg, step_next;
  logic [PW-1:0] prescale_reg, prescale_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [TW-1:0] dur_ticks_reg, dur_ticks_next;
  logic [11:0]   freq_reg, freq_next;
  logic          note_on_reg, note_on_next;
  logic          done_reg, done_next;
  logic [11:0]   dec_freq;
  logic          tick_end, play_end, gap_end, seq_end;

  // Read is addressed by step_next so the entry is already registered during LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) table_mem[wr_addr] <= entry_t'(wr_data);
    rd_data_reg <= table_mem[step_next];
  end

  note_to_freq u_note_to_freq (
    .note  (rd_data_reg.note),
    .sharp (rd_data_reg.sharp),
    .oct   (rd_data_reg.oct),
    .freq  (dec_freq)
  );

  assign tick_end = (prescale_reg == PW'(TICK_DIV - 1));
  assign play_end = tick_end && (tick_reg == dur_ticks_reg - 1'b1);
  assign gap_end  = tick_end && (tick_reg == TW'(GAP_TICKS - 1));

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    prescale_next  = prescale_reg;
    tick_next      = tick_reg;
    dur_ticks_next = dur_ticks_reg;
    freq_next      = freq_reg;
    note_on_next   = note_on_reg;
    done_next      = 1'b0;
    seq_end        = 1'b0;

    if (state_reg == S_PLAY || state_reg == S_GAP) begin
      if (tick_end) begin
        prescale_next = '0;
        tick_next     = tick_reg + 1'b1;
      end else begin
        prescale_next = prescale_reg + 1'b1;
      end
    end

    if (stop) begin
      state_next   = S_IDLE;
      note_on_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            step_next  = '0;
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          if (rd_data_reg.note == NOTE_END) begin
            seq_end = 1'b1;
          end else begin
            freq_next      = dec_freq;
            note_on_next   = ~rd_data_reg.rest;
            prescale_next  = '0;
            tick_next      = '0;
            dur_ticks_next = TW'((int'(rd_data_reg.dur) + 1) * UNIT_TICKS);
            state_next     = S_PLAY;
          end
        end
        S_PLAY: begin
          if (play_end) begin
            note_on_next  = 1'b0;
            prescale_next = '0;
            tick_next     = '0;
            state_next    = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            if (step_reg == AW'(DEPTH - 1)) begin
              step_next = '0;
              seq_end   = 1'b1;
            end else begin
              step_next  = step_reg + 1'b1;
              state_next = S_LOAD;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase

      if (seq_end) begin
`ifdef SEQ_LOOP_EN
        // An END at entry 0 would otherwise reload forever with nothing to play.
        if (state_reg == S_LOAD && step_reg == '0) begin
          state_next   = S_IDLE;
          note_on_next = 1'b0;
          done_next    = 1'b1;
        end else begin
          step_next  = '0;
          state_next = S_LOAD;
        end
`else
        state_next   = S_IDLE;
        note_on_next = 1'b0;
        done_next    = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      step_reg      <= '0;
      prescale_reg  <= '0;
      tick_reg      <= '0;
      dur_ticks_reg <= '0;
      freq_reg      <= F_RESET;
      note_on_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      prescale_reg  <= prescale_next;
      tick_reg      <= tick_next;
      dur_ticks_reg <= dur_ticks_next;
      freq_reg      <= freq_next;
      note_on_reg   <= note_on_next;
      done_reg      <= done_next;
    end
  end

  assign freq    = freq_reg;
  assign note_on = note_on_reg;
  assign busy    = (state_reg != S_IDLE);
  assign step    = step_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, UNIT_TICKS=2, GAP_TICKS=1, DEPTH=16.
// A note of duration d plays (d+1)*8 cycles, followed by a 4-cycle gap.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [9:0]  wr_data;
  logic [11:0] freq;
  logic        note_on;
  logic        busy;
  logic [3:0]  step;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  note_sequencer #(
    .DEPTH(16), .AW(4), .TICK_DIV(4), .UNIT_TICKS(2), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .freq(freq), .note_on(note_on), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rest;
    logic [1:0] oct;
    logic       sharp;
    logic [2:0] note;
    logic [2:0] dur;
    int         exp_freq;
    logic       exp_on;
  } vec_t;

  vec_t vecs[11];
  int   nat[7];
  localparam logic [9:0] END_WORD = 10'b0_00_0_111_000;

  function automatic logic [9:0] pack(logic rest, logic [1:0] oct, logic sharp,
                                      logic [2:0] note, logic [2:0] dur);
    return {rest, oct, sharp, note, dur};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [9:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    int d;
    int hi;
    vecs[0]  = '{0, 2'd0, 0, 3'd5, 3'd1, 440,  1};  // A
    vecs[1]  = '{0, 2'd1, 1, 3'd0, 3'd0, 554,  1};  // C# up one
    vecs[2]  = '{0, 2'd2, 1, 3'd2, 3'd0, 1320, 1};  // E# = E, up two
    vecs[3]  = '{0, 2'd3, 0, 3'd6, 3'd0, 247,  1};  // B down one
    vecs[4]  = '{1, 2'd0, 0, 3'd4, 3'd0, 392,  0};  // rest (G)
    vecs[5]  = '{0, 2'd0, 1, 3'd3, 3'd2, 370,  1};  // F#
    vecs[6]  = '{0, 2'd1, 0, 3'd1, 3'd0, 586,  1};  // D up one
    vecs[7]  = '{0, 2'd3, 1, 3'd4, 3'd0, 207,  1};  // G# down one
    vecs[8]  = '{0, 2'd2, 1, 3'd5, 3'd0, 1864, 1};  // A# up two
    vecs[9]  = '{0, 2'd2, 0, 3'd6, 3'd0, 1976, 1};  // max frequency
    vecs[10] = '{0, 2'd3, 0, 3'd0, 3'd0, 130,  1};  // C down one
    nat = '{261, 293, 330, 349, 392, 440, 494};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("reset_freq", freq, 440);
    check("reset_note_on", note_on, 0);
    check("reset_busy", busy, 0);
    check("reset_step", step, 0);
    check("reset_done", done, 0);

    // Single-entry melodies: entry0 = vector, entry1 = END
    for (int i = 0; i < 11; i++) begin
      wr(4'd0, pack(vecs[i].rest, vecs[i].oct, vecs[i].sharp, vecs[i].note, vecs[i].dur));
      wr(4'd1, END_WORD);
      pulse_start();
      check("load_busy", busy, 1);
      cyc(1);
      $display("vec %0d: freq=%0d note_on=%0d step=%0d", i, freq, note_on, step);
      check("vec_freq", freq, vecs[i].exp_freq);
      check("vec_note_on", note_on, vecs[i].exp_on);
      check("vec_step0", step, 0);
      d = (int'(vecs[i].dur) + 1) * 8;
      cyc(d - 1);
      check("play_last_note_on", note_on, vecs[i].exp_on);
      check("play_last_busy", busy, 1);
      cyc(1);
      check("gap_note_on", note_on, 0);
      check("gap_freq_hold", freq, vecs[i].exp_freq);
      cyc(4);
      check("load_end_step", step, 1);
      check("load_end_done", done, 0);
      cyc(1);
`ifdef SEQ_LOOP_EN
      check("loop_busy", busy, 1);
      check("loop_step", step, 0);
      check("loop_done", done, 0);
`else
      check("end_done", done, 1);
      check("end_busy", busy, 0);
`endif
      cyc(1);
      check("done_one_cycle", done, 0);
      pulse_stop();
      cyc(1);
    end

    // Rest then A: gate silent for the whole rest, step advances to the A
    wr(4'd0, pack(1'b1, 2'd0, 1'b0, 3'd4, 3'd0));
    wr(4'd1, pack(1'b0, 2'd0, 1'b0, 3'd5, 3'd0));
    wr(4'd2, END_WORD);
    pulse_start();
    cyc(1);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (note_on) hi++;
      if (k < 7) cyc(1);
    end
    check("rest_silent", hi, 0);
    check("rest_step", step, 0);
    cyc(5);
    check("rest_next_step", step, 1);
    cyc(1);
    check("after_rest_on", note_on, 1);
    check("after_rest_freq", freq, 440);
    // stop mid-PLAY
    cyc(3);
    pulse_stop();
    $display("stop: busy=%0d note_on=%0d freq=%0d", busy, note_on, freq);
    check("stop_busy", busy, 0);
    check("stop_note_on", note_on, 0);
    check("stop_freq_hold", freq, 440);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) hi++;
      cyc(1);
    end
    check("stop_no_done", hi, 0);

    // Write during play, then start+stop while busy and while idle
    wr(4'd0, pack(1'b0, 2'd0, 1'b0, 3'd5, 3'd1));
    wr(4'd1, END_WORD);
    pulse_start();
    cyc(2);
    wr(4'd0, pack(1'b0, 2'd0, 1'b0, 3'd0, 3'd1));
    check("write_during_play_freq", freq, 440);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_note_on", note_on, 0);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_idle_busy", busy, 0);
    cyc(1);
    check("startstop_idle_done", done, 0);
    pulse_start();
    cyc(1);
    check("rewritten_freq", freq, 261);
    pulse_stop();
    cyc(1);

    // Full table, no END: plays steps 0..15, then wraps
    for (int k = 0; k < 16; k++) wr(4'(k), pack(1'b0, 2'd0, 1'b0, 3'(k % 7), 3'd0));
    pulse_start();
    cyc(1);
    for (int k = 0; k < 16; k++) begin
      $display("full: step=%0d freq=%0d", step, freq);
      check("full_step", step, k);
      check("full_freq", freq, nat[k % 7]);
      if (k < 15) cyc(13);
    end
    cyc(12);
    check("wrap_step", step, 0);
`ifdef SEQ_LOOP_EN
    check("wrap_busy", busy, 1);
    cyc(1);
    check("wrap_replay_freq", freq, 261);
    check("wrap_replay_on", note_on, 1);
`else
    check("wrap_done", done, 1);
    check("wrap_busy", busy, 0);
`endif
    pulse_stop();
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
